instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 193 +++++++++++++++++++
 tb/tb_instr_fetch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch: pc intake, in-order memory requests, decode queue
// Optional feature macro: IFETCH_PERF_CNT_EN (adds fetch_cnt / kill_cnt counters)
module instr_fetch #(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [63:0]             pc_in,
  input  logic                    pc_valid,
  output logic                    pc_ready,
  input  logic                    redirect,
  output logic                    mem_req,
  output logic [63:0]             mem_addr,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [31:0]             mem_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [63:0]             out_pc,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0]             fetch_cnt,
  output logic [31:0]             kill_cnt,
`endif
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL_W  = CW'(DEPTH);
  localparam logic [CW-1:0] MAXO_W  = CW'(MAX_OUTST);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic [63:0]   addr_q, addr_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] kill_q, kill_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0] twptr_q, twptr_d, trptr_q, trptr_d;

  logic [31:0]   instr_mem [DEPTH];
  logic [63:0]   pc_mem    [DEPTH];
  logic [63:0]   tag_mem   [DEPTH];

  logic          pc_fire, gnt_fire, rsp_live, push, pop;
  logic [CW-1:0] inflight;

  // A registered-but-ungranted request already owns a queue slot, so it is
  // counted with the granted ones; otherwise the queue could be overrun.
  always_comb begin
    inflight = outst_q + CW'(req_q);
    pc_ready = !rst && !redirect && (state_q != DRAIN)
               && (({1'b0, count_q} + {1'b0, inflight}) < DEPTH_W)
               && (inflight < MAXO_W)
               && (!req_q || mem_gnt);
  end

  assign pc_fire  = pc_valid && pc_ready;
  assign gnt_fire = req_q && mem_gnt;
  assign rsp_live = mem_rvalid && (state_q != DRAIN) && !redirect && (outst_q != '0);
  assign push     = rsp_live;
  assign pop      = out_valid && out_ready;

  // Next-state: request register, tag/queue pointers, outstanding/kill counts, FSM
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    kill_d  = kill_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    twptr_d = twptr_q;
    trptr_d = trptr_q;

    if (pc_fire) begin
      req_d  = 1'b1;
      addr_d = pc_in;
    end else if (gnt_fire) begin
      req_d  = 1'b0;
    end

    if (gnt_fire) twptr_d = twptr_q + PW'(1);
    if (rsp_live) trptr_d = trptr_q + PW'(1);
    if (push)     wptr_d  = wptr_q + PW'(1);
    if (pop)      rptr_d  = rptr_q + PW'(1);

    outst_d = outst_q + CW'(gnt_fire) - CW'(rsp_live);
    count_d = count_q + CW'(push) - CW'(pop);

    if (redirect) begin
      // Everything granted (including this cycle) minus a response landing now
      // becomes the number of responses to swallow.
      kill_d  = outst_q + kill_q + CW'(gnt_fire)
                - CW'(mem_rvalid && ((outst_q != '0) || (kill_q != '0)));
      req_d   = 1'b0;
      outst_d = '0;
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      twptr_d = '0;
      trptr_d = '0;
      state_d = (kill_d != '0) ? DRAIN : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (pc_fire) state_d = FETCH;
        FETCH:   if ((outst_d == '0) && !req_d) state_d = IDLE;
        DRAIN: begin
          if (mem_rvalid && (kill_q != '0)) kill_d = kill_q - CW'(1);
          if (kill_d == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and control registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      outst_q <= '0;
      kill_q  <= '0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      twptr_q <= '0;
      trptr_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      outst_q <= outst_d;
      kill_q  <= kill_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      twptr_q <= twptr_d;
      trptr_q <= trptr_d;
    end
  end

  // Storage arrays: tag captured at grant, instruction+tag captured at response
  always_ff @(posedge clk) begin
    if (gnt_fire && !redirect) tag_mem[twptr_q] <= addr_q;
    if (push) begin
      instr_mem[wptr_q] <= mem_rdata;
      pc_mem[wptr_q]    <= tag_mem[trptr_q];
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign occupancy = count_q;
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_mem[rptr_q] : '0;
  assign out_pc    = out_valid ? pc_mem[rptr_q]    : '0;

`ifdef IFETCH_PERF_CNT_EN
  logic        discard;
  logic [31:0] fetch_cnt_q, kill_cnt_q;

  assign discard = mem_rvalid && (redirect || (state_q == DRAIN))
                   && ((outst_q != '0) || (kill_q != '0));

  // Saturating event counters for decode transfers and swallowed responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      if (pop && (fetch_cnt_q != '1))    fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (discard && (kill_cnt_q != '1)) kill_cnt_q  <= kill_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign kill_cnt  = kill_cnt_q;
`endif

`ifndef SYNTHESIS
  a_no_full_write: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == FULL_W)));
  a_no_stray_rsp: assert property (@(posedge clk) disable iff (rst)
    !(mem_rvalid && (outst_q == '0) && (kill_q == '0)));
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        redirect;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [2:0]  occupancy;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] kill_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.DEPTH(4), .MAX_OUTST(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .redirect   (redirect),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
`ifdef IFETCH_PERF_CNT_EN
    .fetch_cnt  (fetch_cnt),
    .kill_cnt   (kill_cnt),
`endif
    .occupancy  (occupancy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] src_q[$];
  logic [63:0] pend_q[$];
  logic [63:0] exp_q[$];
  bit          auto_rsp = 1'b1;
  bit          gnt_en   = 1'b1;
  int          max_occ  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return {16'hBEEF, pc[15:0]};
  endfunction

  // One clock: drive inputs from the models, score any decode transfer, advance.
  task automatic tick();
    logic        g, pf;
    logic [63:0] ga, e;
    mem_rvalid = auto_rsp && (pend_q.size() > 0);
    mem_rdata  = mem_rvalid ? instr_of(pend_q[0]) : 32'h0;
    mem_gnt    = gnt_en;
    pc_valid   = (src_q.size() > 0);
    pc_in      = pc_valid ? src_q[0] : 64'h0;
    #1;
    g  = mem_req && mem_gnt;
    ga = mem_addr;
    pf = pc_valid && pc_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_extra", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e);
        check("out_instr", 64'(out_instr), 64'(instr_of(e)));
      end
    end
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    @(posedge clk);
    if (mem_rvalid) void'(pend_q.pop_front());
    if (g) pend_q.push_back(ga);
    if (pf) void'(src_q.pop_front());
    @(negedge clk);
  endtask

  task automatic run_until_done(input string tag, input int limit);
    int n = 0;
    while ((exp_q.size() > 0 || pend_q.size() > 0 || src_q.size() > 0) && n < limit) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_q.size() + pend_q.size() + src_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; redirect = 1'b0; pc_valid = 1'b1; pc_in = 64'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; out_ready = 1'b0;

    // Reset values
    #3;
    check("rst_pc_ready", 64'(pc_ready), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; pc_valid = 1'b0;

    // Streaming fetch with immediate grant and one-cycle response
    out_ready = 1'b1; max_occ = 0;
    for (int i = 0; i < 4; i++) begin src_q.push_back(64'(i)); exp_q.push_back(64'(i)); end
    run_until_done("t1_done", 60);
    check("t1_max_occ_le1", 64'(max_occ <= 1), 64'd1);
    check("t1_idle_req", 64'(mem_req), 64'd0);

    // Decode stalled: queue fills to 4 and holds its head
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) src_q.push_back(64'(i));
    for (int i = 0; i < 20; i++) tick();
    check("t2_occupancy", 64'(occupancy), 64'd4);
    check("t2_pc_ready", 64'(pc_ready), 64'd0);
    check("t2_accepted", 64'(src_q.size()), 64'd4);
    check("t2_head_pc", out_pc, 64'd0);
    tick();
    check("t2_head_pc_stable", out_pc, 64'd0);
    check("t2_head_instr_stable", 64'(out_instr), 64'hBEEF0000);
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(i));
    out_ready = 1'b1;
    run_until_done("t2_done", 80);

    // Two granted fetches killed by redirect before any response
    auto_rsp = 1'b0;
    src_q.push_back(64'd10); src_q.push_back(64'd11);
    n = 0;
    while (pend_q.size() < 2 && n < 20) begin tick(); n++; end
    check("t3_two_granted", 64'(pend_q.size()), 64'd2);
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    check("t3_out_valid_after_redirect", 64'(out_valid), 64'd0);
    check("t3_pc_ready_in_drain", 64'(pc_ready), 64'd0);
    auto_rsp = 1'b1;
    src_q.push_back(64'd40); exp_q.push_back(64'd40);
    run_until_done("t3_done", 40);
`ifdef IFETCH_PERF_CNT_EN
    check("t3_kill_cnt", 64'(kill_cnt), 64'd2);
`endif

    // Grant withheld for 5 cycles: request held stable
    gnt_en = 1'b0;
    src_q.push_back(64'd5); exp_q.push_back(64'd5);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_req_held", 64'(mem_req), 64'd1);
      check("t4_addr_held", mem_addr, 64'd5);
      tick();
    end
    gnt_en = 1'b1;
    tick();
    check("t4_single_outstanding", 64'(pend_q.size()), 64'd1);
    check("t4_req_dropped", 64'(mem_req), 64'd0);
    run_until_done("t4_done", 20);

    // Push and pop in the same cycle at occupancy 2
    out_ready = 1'b0;
    src_q.push_back(64'd20); src_q.push_back(64'd21);
    n = 0;
    while (!(occupancy == 3'd2 && pend_q.size() == 0) && n < 20) begin tick(); n++; end
    check("t5_occ_two", 64'(occupancy), 64'd2);
    auto_rsp = 1'b0;
    src_q.push_back(64'd22);
    n = 0;
    while (pend_q.size() < 1 && n < 20) begin tick(); n++; end
    exp_q.push_back(64'd20); exp_q.push_back(64'd21); exp_q.push_back(64'd22);
    auto_rsp = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_occ_unchanged", 64'(occupancy), 64'd2);
    check("t5_head_after_pop", out_pc, 64'd21);
    out_ready = 1'b1;
    run_until_done("t5_done", 20);

    // Redirect coinciding with a response: response dropped, queue emptied
    out_ready = 1'b0;
    src_q.push_back(64'd29);
    n = 0;
    while (!(occupancy == 3'd1 && pend_q.size() == 0) && n < 20) begin tick(); n++; end
    auto_rsp = 1'b0;
    src_q.push_back(64'd30);
    n = 0;
    while (pend_q.size() < 1 && n < 20) begin tick(); n++; end
    auto_rsp = 1'b1; redirect = 1'b1;
    tick();
    redirect = 1'b0;
    check("t6_out_valid_low", 64'(out_valid), 64'd0);
    check("t6_occ_zero", 64'(occupancy), 64'd0);
    tick(); tick();
    check("t6_still_empty", 64'(out_valid), 64'd0);
    check("t6_pc_ready_idle", 64'(pc_ready), 64'd1);
    out_ready = 1'b1;
    src_q.push_back(64'd31); exp_q.push_back(64'd31);
    run_until_done("t6_done", 20);
`ifdef IFETCH_PERF_CNT_EN
    check("t6_kill_cnt", 64'(kill_cnt), 64'd3);
    check("t6_fetch_cnt", 64'(fetch_cnt), 64'd18);
`endif

    // Asynchronous reset with 2 queued and 1 outstanding
    out_ready = 1'b0;
    src_q.push_back(64'd50); src_q.push_back(64'd51);
    n = 0;
    while (!(occupancy == 3'd2 && pend_q.size() == 0) && n < 20) begin tick(); n++; end
    auto_rsp = 1'b0;
    src_q.push_back(64'd52);
    n = 0;
    while (pend_q.size() < 1 && n < 20) begin tick(); n++; end
    check("t7_pre_occ", 64'(occupancy), 64'd2);
    check("t7_pre_addr", mem_addr, 64'd52);
    mem_rvalid = 1'b0; pc_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t7_mem_req", 64'(mem_req), 64'd0);
    check("t7_mem_addr", mem_addr, 64'd0);
    check("t7_out_valid", 64'(out_valid), 64'd0);
    check("t7_out_instr", 64'(out_instr), 64'd0);
    check("t7_out_pc", out_pc, 64'd0);
    check("t7_occupancy", 64'(occupancy), 64'd0);
    check("t7_pc_ready", 64'(pc_ready), 64'd0);
`ifdef IFETCH_PERF_CNT_EN
    check("t7_fetch_cnt", 64'(fetch_cnt), 64'd0);
`endif
    pend_q.delete(); src_q.delete(); exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("t7_release_pc_ready", 64'(pc_ready), 64'd1);
    @(negedge clk);
    auto_rsp = 1'b1; out_ready = 1'b1;
    src_q.push_back(64'd60); exp_q.push_back(64'd60);
    run_until_done("t7_done", 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
